// File: rtl/i281_pkg.sv
// i281_pkg: shared constants and types for the i281 instruction decoder.
//   - opcode nibble values (instr[15:12]) and sub-op codes (instr[9:8])
//   - bit positions of the one-hot operation field op[22:0]
//   - INSTR_W / OP_W widths and the buffered entry record
package i281_pkg;

  localparam int INSTR_W  = 16;
  localparam int OP_W     = 27;
  localparam int ONEHOT_W = 23;
  localparam int IMM_W    = 8;
  localparam int PC_W     = 6;

  typedef enum logic [3:0] {
    OPC_NOOP   = 4'h0,
    OPC_INPUT  = 4'h1,
    OPC_MOVE   = 4'h2,
    OPC_LOADI  = 4'h3,
    OPC_ADD    = 4'h4,
    OPC_ADDI   = 4'h5,
    OPC_SUB    = 4'h6,
    OPC_SUBI   = 4'h7,
    OPC_LOAD   = 4'h8,
    OPC_LOADF  = 4'h9,
    OPC_STORE  = 4'hA,
    OPC_STOREF = 4'hB,
    OPC_SHIFT  = 4'hC,
    OPC_CMP    = 4'hD,
    OPC_JUMP   = 4'hE,
    OPC_BRANCH = 4'hF
  } opcode_e;

  // Sub-op codes carried in instr[9:8].
  typedef enum logic [1:0] {SUB_IN_C, SUB_IN_CF, SUB_IN_D, SUB_IN_DF} input_sub_e;
  typedef enum logic [1:0] {SUB_BR_E, SUB_BR_NE, SUB_BR_G, SUB_BR_GE} branch_sub_e;

  // Bit index of each operation inside op[22:0].
  localparam logic [4:0] OP_NOOP    = 5'd0;
  localparam logic [4:0] OP_INPUTC  = 5'd1;
  localparam logic [4:0] OP_INPUTCF = 5'd2;
  localparam logic [4:0] OP_INPUTD  = 5'd3;
  localparam logic [4:0] OP_INPUTDF = 5'd4;
  localparam logic [4:0] OP_MOVE    = 5'd5;
  localparam logic [4:0] OP_LOADI   = 5'd6;
  localparam logic [4:0] OP_ADD     = 5'd7;
  localparam logic [4:0] OP_ADDI    = 5'd8;
  localparam logic [4:0] OP_SUB     = 5'd9;
  localparam logic [4:0] OP_SUBI    = 5'd10;
  localparam logic [4:0] OP_LOAD    = 5'd11;
  localparam logic [4:0] OP_LOADF   = 5'd12;
  localparam logic [4:0] OP_STORE   = 5'd13;
  localparam logic [4:0] OP_STOREF  = 5'd14;
  localparam logic [4:0] OP_SHIFTL  = 5'd15;
  localparam logic [4:0] OP_SHIFTR  = 5'd16;
  localparam logic [4:0] OP_CMP     = 5'd17;
  localparam logic [4:0] OP_JUMP    = 5'd18;
  localparam logic [4:0] OP_BRE     = 5'd19;
  localparam logic [4:0] OP_BRNE    = 5'd20;
  localparam logic [4:0] OP_BRG     = 5'd21;
  localparam logic [4:0] OP_BRGE    = 5'd22;

  // One decoded instruction as held in the main / skid registers.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  pc;
  } dec_entry_t;

endpackage

// File: rtl/i281_instr_decoder_if.sv
// i281_instr_decoder_if: fetch-side and control-side handshake bundle.
//   fetch side  : in_valid, in_ready, instr_in[15:0], pc_in[5:0], flush
//   control side: out_valid, out_ready, op_out[26:0], imm_out[7:0], pc_out[5:0]
// Modports: slave = the decoder, master = the surrounding pipeline.
interface i281_instr_decoder_if;
  import i281_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    op_out;
  logic [IMM_W-1:0]   imm_out;
  logic [PC_W-1:0]    pc_out;

  modport slave (
    input  in_valid, instr_in, pc_in, flush, out_ready,
    output in_ready, out_valid, op_out, imm_out, pc_out
  );

  modport master (
    output in_valid, instr_in, pc_in, flush, out_ready,
    input  in_ready, out_valid, op_out, imm_out, pc_out
  );

endinterface

// File: rtl/i281_op_onehot.sv
// i281_op_onehot: combinational instruction decode.
//   instr[15:0] -> op[26:0] = {instr[11:10], instr[9:8], one-hot[22:0]}
// The register fields are copied for every opcode, even where [9:8]
// is a sub-op selector rather than RY.
module i281_op_onehot
  import i281_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op
);

  logic [4:0] bit_idx;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    bit_idx = OP_NOOP;
    case (opcode_e'(instr[15:12]))
      OPC_NOOP:   bit_idx = OP_NOOP;
      OPC_INPUT:
        case (input_sub_e'(instr[9:8]))
          SUB_IN_C:  bit_idx = OP_INPUTC;
          SUB_IN_CF: bit_idx = OP_INPUTCF;
          SUB_IN_D:  bit_idx = OP_INPUTD;
          SUB_IN_DF: bit_idx = OP_INPUTDF;
          default:   bit_idx = OP_INPUTC;
        endcase
      OPC_MOVE:   bit_idx = OP_MOVE;
      OPC_LOADI:  bit_idx = OP_LOADI;
      OPC_ADD:    bit_idx = OP_ADD;
      OPC_ADDI:   bit_idx = OP_ADDI;
      OPC_SUB:    bit_idx = OP_SUB;
      OPC_SUBI:   bit_idx = OP_SUBI;
      OPC_LOAD:   bit_idx = OP_LOAD;
      OPC_LOADF:  bit_idx = OP_LOADF;
      OPC_STORE:  bit_idx = OP_STORE;
      OPC_STOREF: bit_idx = OP_STOREF;
      // Shift direction only looks at bit 8; bit 9 is don't-care.
      OPC_SHIFT:  bit_idx = instr[8] ? OP_SHIFTR : OP_SHIFTL;
      OPC_CMP:    bit_idx = OP_CMP;
      OPC_JUMP:   bit_idx = OP_JUMP;
      OPC_BRANCH:
        case (branch_sub_e'(instr[9:8]))
          SUB_BR_E:  bit_idx = OP_BRE;
          SUB_BR_NE: bit_idx = OP_BRNE;
          SUB_BR_G:  bit_idx = OP_BRG;
          SUB_BR_GE: bit_idx = OP_BRGE;
          default:   bit_idx = OP_BRE;
        endcase
      default:    bit_idx = OP_NOOP;
    endcase
  end

  assign op = {instr[11:8], ONEHOT_W'(1) << bit_idx};

endmodule

// File: rtl/i281_instr_decoder.sv
// i281_instr_decoder: registered i281 instruction decoder with a two-entry
// skid buffer between instruction fetch and the control logic.
//   clk, rst_n  : clock, asynchronous active-low reset
//   dec (slave) : in_valid/in_ready/instr_in/pc_in/flush from fetch,
//                 out_valid/out_ready/op_out/imm_out/pc_out to control
//   instr_count, stall_count : 16-bit saturating statistics, present only
//                 when I281_DECODE_STATS_EN is defined
// Decode happens before the buffer, so M and S hold finished entries.
// M drives the outputs directly; S catches the word accepted on the cycle
// in_ready is still high while M is stalled. in_ready is a register equal
// to ~S_valid, so an accept can never arrive while S is occupied.
module i281_instr_decoder
  import i281_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  i281_instr_decoder_if.slave   dec
`ifdef I281_DECODE_STATS_EN
  ,
  output logic [15:0]           instr_count,
  output logic [15:0]           stall_count
`endif
);

  logic [OP_W-1:0] in_op;
  dec_entry_t      in_entry;
  dec_entry_t      m_q;
  dec_entry_t      s_q;
  logic            m_valid_q;
  logic            s_valid_q;
  logic            in_ready_q;

  logic            accept;
  logic            drain;
  logic            m_free;
  logic            m_valid_d;
  logic            s_valid_d;
  logic            load_m_in;
  logic            load_m_s;
  logic            load_s;

  i281_op_onehot u_onehot (
    .instr (dec.instr_in),
    .op    (in_op)
  );

  assign in_entry = '{op: in_op, imm: dec.instr_in[7:0], pc: dec.pc_in};

  assign accept = dec.in_valid & in_ready_q;
  assign drain  = m_valid_q & dec.out_ready;
  assign m_free = ~m_valid_q | drain;

  // Buffer steering. Flush wins over everything; a word accepted on the
  // flush cycle is simply never loaded.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (dec.flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        load_m_s  = 1'b1;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        load_m_in = 1'b1;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      load_s    = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset too, because op_out/imm_out/pc_out
  // must read zero out of reset, not just be qualified by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      s_q        <= '0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= ~s_valid_d;
      if (load_m_in) begin
        m_q <= in_entry;
      end else if (load_m_s) begin
        m_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_entry;
      end
    end
  end

  assign dec.in_ready  = in_ready_q;
  assign dec.out_valid = m_valid_q;
  assign dec.op_out    = m_q.op;
  assign dec.imm_out   = m_q.imm;
  assign dec.pc_out    = m_q.pc;

`ifdef I281_DECODE_STATS_EN
  // Counts are taken from the registered outputs, so a handshake on a
  // flush cycle still counts as consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (m_valid_q && dec.out_ready && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end
      if (m_valid_q && !dec.out_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i281_instr_decoder.sv
// tb_i281_instr_decoder: self-checking bench for i281_instr_decoder.
// Expected decoded entries are pushed to a scoreboard queue when the bench
// sees an accept and popped/compared on each output handshake.
module tb_i281_instr_decoder;

  typedef struct {
    logic [26:0] op;
    logic [7:0]  imm;
    logic [5:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  i281_instr_decoder_if dif ();

`ifdef I281_DECODE_STATS_EN
  logic [15:0] instr_count;
  logic [15:0] stall_count;
`endif

  i281_instr_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec         (dif)
`ifdef I281_DECODE_STATS_EN
    ,
    .instr_count (instr_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic last_accept;
  logic hold_pending = 1'b0;
  exp_t held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the opcode table.
  function automatic exp_t expect_of(input logic [15:0] w, input logic [5:0] pc);
    int base[16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
    int b;
    logic [22:0] hot;
    exp_t r;
    b = base[w[15:12]];
    if (w[15:12] == 4'h1 || w[15:12] == 4'hF) b = b + int'(w[9:8]);
    if (w[15:12] == 4'hC) b = b + int'(w[8]);
    hot = '0;
    hot[b] = 1'b1;
    r.op  = {w[11:8], hot};
    r.imm = w[7:0];
    r.pc  = pc;
    return r;
  endfunction

  // One clock: sample at negedge, update scoreboard, advance to posedge+1.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (hold_pending) begin
      check("hold_op", dif.op_out, held.op);
      check("hold_imm", dif.imm_out, held.imm);
      check("hold_pc", dif.pc_out, held.pc);
      hold_pending = 1'b0;
    end
    if (dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", dif.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("op", dif.op_out, e.op);
        check("imm", dif.imm_out, e.imm);
        check("pc", dif.pc_out, e.pc);
        check("onehot", $countones(dif.op_out[22:0]), 1);
      end
    end
    if (dif.out_valid && !dif.out_ready && !dif.flush) begin
      held.op  = dif.op_out;
      held.imm = dif.imm_out;
      held.pc  = dif.pc_out;
      hold_pending = 1'b1;
    end
    last_accept = dif.in_valid & dif.in_ready;
    if (last_accept && !dif.flush) sb.push_back(expect_of(dif.instr_in, dif.pc_in));
    if (dif.flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    dif.in_valid  = 1'b0;
    dif.flush     = 1'b0;
    dif.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    hold_pending = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] words[8];
    int k;
    int n;
    exp_t e;

    dif.in_valid  = 1'b0;
    dif.instr_in  = '0;
    dif.pc_in     = '0;
    dif.flush     = 1'b0;
    dif.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", dif.out_valid, 0);
    check("rst_in_ready", dif.in_ready, 1);
    check("rst_op", dif.op_out, 0);
    check("rst_imm", dif.imm_out, 0);
    check("rst_pc", dif.pc_out, 0);
`ifdef I281_DECODE_STATS_EN
    check("rst_instr_count", instr_count, 0);
    check("rst_stall_count", stall_count, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD RX=1 RY=2: visible one cycle after accept
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.instr_in  = 16'h4600;
    dif.pc_in     = 6'd3;
    step();
    dif.in_valid = 1'b0;
    check("add_out_valid", dif.out_valid, 1);
    check("add_op", dif.op_out, 27'h3000080);
    drain("add_drain");

    // Sweep all opcodes x [9:8] at full rate
    k = 0;
    n = 0;
    dif.out_ready = 1'b1;
    while (k < 64 && n < 200) begin
      dif.in_valid = 1'b1;
      dif.instr_in = {k[5:2], k[1:0] ^ k[3:2], k[1:0], 8'($urandom)};
      dif.pc_in    = k[5:0];
      step();
      if (last_accept) k++;
      n++;
    end
    check("sweep_count", k, 64);
    check("sweep_throughput", n, 64);
    drain("sweep_drain");

    // Stream 8 words with out_ready low, then release
    for (int i = 0; i < 8; i++) words[i] = 16'(16'h1000 * (i + 2) + 16'h0300 + 16'(i));
    k = 0;
    dif.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      dif.in_valid = 1'b1;
      dif.instr_in = words[k];
      dif.pc_in    = 6'(20 + k);
      step();
      if (last_accept) k++;
    end
    check("stall_accepts", k, 2);
    check("stall_in_ready", dif.in_ready, 0);
    check("stall_out_valid", dif.out_valid, 1);
    dif.out_ready = 1'b1;
    n = 0;
    while (k < 8 && n < 40) begin
      dif.in_valid = 1'b1;
      dif.instr_in = words[k];
      dif.pc_in    = 6'(20 + k);
      step();
      if (last_accept) k++;
      n++;
    end
    check("release_cycles", n, 7);
    drain("stream_drain");

    // Flush with both entries full and in_valid high
    dif.out_ready = 1'b0;
    k = 0;
    n = 0;
    while (dif.in_ready && n < 10) begin
      dif.in_valid = 1'b1;
      dif.instr_in = 16'h5A00 + 16'(n);
      dif.pc_in    = 6'(40 + n);
      step();
      n++;
    end
    check("full_in_ready", dif.in_ready, 0);
    dif.in_valid = 1'b1;
    dif.instr_in = 16'h7777;
    dif.flush    = 1'b1;
    step();
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    check("flush_out_valid", dif.out_valid, 0);
    check("flush_in_ready", dif.in_ready, 1);
    dif.out_ready = 1'b1;
    repeat (3) step();
    check("flush_idle_valid", dif.out_valid, 0);

    // Flush while M drains and a new word is accepted: M consumed, word dropped
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.instr_in  = 16'hD123;
    dif.pc_in     = 6'd50;
    step();
    dif.instr_in = 16'hE0FF;
    dif.pc_in    = 6'd51;
    dif.flush    = 1'b1;
    step();
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    check("flush2_out_valid", dif.out_valid, 0);
    check("flush2_sb_empty", sb.size(), 0);
    repeat (2) step();
    dif.in_valid = 1'b1;
    dif.instr_in = 16'hF2AA;
    dif.pc_in    = 6'd52;
    step();
    drain("post_flush_drain");

    // Asynchronous reset mid-stream
    dif.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dif.in_valid = 1'b1;
      dif.instr_in = 16'h3C00 + 16'(i);
      dif.pc_in    = 6'(60 + i);
      step();
    end
    dif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", dif.out_valid, 0);
    check("async_in_ready", dif.in_ready, 1);
    check("async_op", dif.op_out, 0);
    sb.delete();
    hold_pending = 1'b0;
    #2;
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    dif.in_valid  = 1'b1;
    dif.instr_in  = 16'hC500;
    dif.pc_in     = 6'd9;
    step();
    dif.in_valid = 1'b0;
    e = expect_of(16'hC500, 6'd9);
    check("post_rst_first_op", dif.op_out, e.op);
    drain("post_rst_drain");

`ifdef I281_DECODE_STATS_EN
    // Statistics: 3 handshakes then 5 stall cycles, then stall saturation
    do_reset();
    dif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dif.in_valid = 1'b1;
      dif.instr_in = 16'h2100 + 16'(i);
      dif.pc_in    = 6'(i);
      step();
    end
    dif.in_valid = 1'b0;
    repeat (2) step();
    check("stats_instr3", instr_count, 3);
    check("stats_stall0", stall_count, 0);
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.instr_in  = 16'h8400;
    step();
    dif.in_valid = 1'b0;
    repeat (5) step();
    check("stats_stall5", stall_count, 5);
    check("stats_instr_hold", instr_count, 3);
    repeat (65530) step();
    check("stats_stall_max", stall_count, 16'hFFFF);
    repeat (5) step();
    check("stats_stall_sat", stall_count, 16'hFFFF);
    drain("stats_drain");
    check("stats_instr4", instr_count, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
